// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction-memory loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a counted little-endian byte stream into instruction memory from address 0,
// zero-fills the remainder and holds the CPU in reset until the image is complete.
module imem_loader #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int unsigned WORDS = 2 ** ADDR_W;
  localparam int unsigned IDX_W = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    BYTES,
    WRITE,
    FILL,
    DONE,
    ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N-1:0]      asm_q, asm_d;

  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic hs;
  logic last_word;

  assign hs        = bus.in_valid & ready_q;
  assign last_word = (32'(addr_q) + 32'd1) == 32'(count_q);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state; outputs are decoded from the next state so they are registered
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    idx_d   = idx_q;
    asm_d   = asm_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        if (hs) begin
          count_d = bus.in_data;
          addr_d  = '0;
          idx_d   = '0;
          asm_d   = '0;
          if (bus.in_data == 8'd0)              state_d = FILL;
          else if (32'(bus.in_data) > WORDS)    state_d = ERR;
          else                                  state_d = BYTES;
        end
      end
      BYTES: begin
        if (hs) begin
          asm_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_word && addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else if (last_word) begin
          state_d = FILL;
          addr_d  = addr_q + ADDR_W'(1);
        end else begin
          state_d = BYTES;
          addr_d  = addr_q + ADDR_W'(1);
          idx_d   = '0;
        end
      end
      FILL: begin
        if (addr_q == LAST_ADDR) state_d = DONE;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      DONE, ERR: begin
        if (start) state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == COUNT) || (state_d == BYTES);
    we_d    = (state_d == WRITE) || (state_d == FILL);
    waddr_d = addr_d;
    wdata_d = (state_d == WRITE) ? asm_d : '0;
    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  assign bus.in_ready = ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
